cmd_packet_buffer: RTL

Parametrised, multi-slot successor to the single fixed 64-byte command-packet ROM that feeds packet_streamer's cmd_ready/cmd_addr/cmd_data port.
- A writer, such as a control-register bridge or a future ARP/UDP responder, fills one slot per command packet and commits it with a length.
- packet_streamer reads the committed slots in FIFO order through the same addr/data port, then releases each slot with cmd_done.
- The block replaces the hard-coded ARP packet and lets several command packets queue.

---
 rtl/cmd_packet_buffer_pkg.sv | 10 +
 rtl/cmd_buf_ram.sv | 21 ++
 rtl/cmd_packet_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/cmd_packet_buffer_pkg.sv
// cmd_packet_buffer_pkg: default geometry and helpers shared by the buffer, its writer bridge and the streamer
package cmd_packet_buffer_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SLOT_W = 2;
  localparam int DEF_DROP_W = 16;
  function automatic int pow2(input int w);
    return 1 << w;
  endfunction
endpackage

// File: rtl/cmd_buf_ram.sv
// cmd_buf_ram: simple dual-port synchronous RAM, registered read, old data on collision, no reset
module cmd_buf_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;
  // write port and registered read port; nonblocking read gives old data on a same-address write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/cmd_packet_buffer.sv
// cmd_packet_buffer: multi-slot FIFO of command packets, written per byte and committed with a length
module cmd_packet_buffer
  import cmd_packet_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int LEN_W  = ADDR_W + 1,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_full,
  output logic              cmd_ready,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_done,
  output logic [SLOT_W:0]   slot_count,
  output logic [DROP_W-1:0] drop_count
);
  localparam int NSLOT = pow2(SLOT_W);
  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(NSLOT);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(pow2(ADDR_W));
  logic [SLOT_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [SLOT_W:0]   count_q, count_d;
  logic [LEN_W-1:0]  len_q [NSLOT];
  logic [LEN_W-1:0]  len_d [NSLOT];
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              commit, reject, rel;
  assign wr_full    = count_q == FULL_CNT;
  assign cmd_ready  = count_q != '0;
  assign slot_count = count_q;
  assign drop_count = drop_q;
  assign cmd_len    = len_q[rp_q];
  assign commit     = wr_commit && !wr_full && wr_len != '0 && wr_len <= LEN_MAX;
  assign reject     = wr_commit && !commit;
  assign rel        = cmd_done && cmd_ready;
  // RAM output is unreset for block-RAM inference, so it is masked to zero until the first read after reset
  assign cmd_data   = rd_valid_q ? ram_rdata : '0;
  cmd_buf_ram #(.DATA_W(DATA_W), .AW(SLOT_W + ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en && !wr_full),
    .waddr ({wp_q, wr_addr}),
    .wdata (wr_data),
    .raddr ({rp_q, cmd_addr}),
    .rdata (ram_rdata)
  );
  // next-state: pointer advance on accepted commit/release, saturating drop count, length capture at old wp
  always_comb begin
    wp_d    = wp_q + SLOT_W'(commit);
    rp_d    = rp_q + SLOT_W'(rel);
    count_d = count_q + (SLOT_W+1)'(commit) - (SLOT_W+1)'(rel);
    drop_d  = reject && !(&drop_q) ? drop_q + DROP_W'(1) : drop_q;
    len_d   = len_q;
    if (commit) len_d[wp_q] = wr_len;
  end
  // queue state registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      len_q      <= '{default: '0};
      rd_valid_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      len_q      <= len_d;
      rd_valid_q <= 1'b1;
    end
  end
endmodule
